// File: rtl/fireball_hit_detect_pkg.sv
// Shared constants and types for the fireball collision responder.
// Imported by the hitbox comparator and the top-level hit FSM.
package fireball_hit_detect_pkg;

    localparam logic [1:0] FIREBALL_DISABLED  = 2'b00;
    localparam logic [1:0] FIREBALL_ENABLED   = 2'b01;
    localparam logic [1:0] FIREBALL_EXPLOSION = 2'b10;

    localparam int unsigned SPRITE_WIDTH  = 32;
    localparam int unsigned SPRITE_HEIGHT = 48;
    localparam int unsigned MIN_X         = 0;
    localparam int unsigned MAX_X         = 639;

    typedef enum logic [1:0] {
        StArmed     = 2'd0,
        StHit       = 2'd1,
        StStun      = 2'd2,
        StWaitClear = 2'd3
    } hit_state_e;

    // Health never wraps below zero.
    function automatic logic [6:0] sat_sub(input logic [6:0] value, input logic [6:0] amount);
        return (value > amount) ? (value - amount) : 7'd0;
    endfunction

endpackage

// File: rtl/hitbox_overlap.sv
// Combinational point-in-hitbox test against a sprite given by its horizontal
// centre and bottom row. Bounds are clamped to the screen, never wrapped.
module hitbox_overlap
    import fireball_hit_detect_pkg::*;
(
    input  logic [9:0] pt_x_i,
    input  logic [9:0] pt_y_i,
    input  logic [9:0] centre_x_i,
    input  logic [9:0] bottom_y_i,
    output logic       overlap_o
);

    localparam logic [10:0] HalfW   = 11'(SPRITE_WIDTH / 2);
    localparam logic [10:0] HeightM = 11'(SPRITE_HEIGHT - 1);
    localparam logic [10:0] MinX    = 11'(MIN_X);
    localparam logic [10:0] MaxX    = 11'(MAX_X);

    logic [10:0] px, py, cx, by;
    logic [10:0] lo_x, hi_x, lo_y;

    always_comb begin
        px = {1'b0, pt_x_i};
        py = {1'b0, pt_y_i};
        cx = {1'b0, centre_x_i};
        by = {1'b0, bottom_y_i};

        lo_x = (cx >= MinX + HalfW) ? (cx - HalfW) : MinX;
        hi_x = (cx + HalfW > MaxX) ? MaxX : (cx + HalfW);
        lo_y = (by >= HeightM) ? (by - HeightM) : 11'd0;

        overlap_o = (px >= lo_x) && (px <= hi_x) && (py >= lo_y) && (py <= by);
    end

endmodule

// File: rtl/fireball_hit_detect.sv
// Fireball-vs-opponent hit responder: registers contact, issues one hit pulse per
// launch, applies damage with saturation and holds the opponent in hitstun.
module fireball_hit_detect
    import fireball_hit_detect_pkg::*;
#(
    parameter logic [6:0]  DAMAGE         = 7'd10,
    parameter logic [6:0]  BLOCK_DAMAGE   = 7'd2,
    parameter logic [6:0]  MAX_HEALTH     = 7'd100,
    parameter int unsigned HITSTUN_CYCLES = 32
) (
    input  logic       clk,
    input  logic       start,
    input  logic [1:0] fb_state,
    input  logic [9:0] fb_x,
    input  logic [9:0] fb_y,
    input  logic [9:0] opp_x,
    input  logic [9:0] opp_y,
    input  logic       opp_blocking,
    output logic       opponent_hit,
    output logic       hitstun,
    output logic [6:0] opp_health,
    output logic       ko
);

    localparam logic [4:0] StunLoad = 5'(HITSTUN_CYCLES - 1);

    hit_state_e state_q, state_d;
    logic       hit_cand_q, hit_cand_d;
    logic [4:0] cnt_q, cnt_d;
    logic [6:0] health_q, health_d;
    logic       ko_q, ko_d;
    logic       opponent_hit_q, opponent_hit_d;
    logic       hitstun_q, hitstun_d;
    logic       overlap;

    hitbox_overlap u_hitbox (
        .pt_x_i     (fb_x),
        .pt_y_i     (fb_y),
        .centre_x_i (opp_x),
        .bottom_y_i (opp_y),
        .overlap_o  (overlap)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        health_d   = health_q;
        ko_d       = ko_q;
        hit_cand_d = overlap && (fb_state == FIREBALL_ENABLED);

        unique case (state_q)
            StArmed: begin
                // Damage lands on the edge into HIT so health moves with the pulse.
                if (hit_cand_q && !ko_q) begin
                    state_d  = StHit;
                    health_d = sat_sub(health_q, opp_blocking ? BLOCK_DAMAGE : DAMAGE);
                    ko_d     = (health_d == 7'd0);
                end
            end
            StHit: begin
                cnt_d   = StunLoad;
                state_d = StStun;
            end
            StStun: begin
                if (cnt_q == 5'd0) begin
                    state_d = StWaitClear;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            StWaitClear: begin
                if (fb_state == FIREBALL_DISABLED) begin
                    state_d = StArmed;
                end
            end
            default: state_d = StArmed;
        endcase

        opponent_hit_d = (state_d == StHit);
        hitstun_d      = (state_d == StStun);
    end

    always_ff @(posedge clk) begin
        if (start) begin
            state_q        <= StArmed;
            hit_cand_q     <= 1'b0;
            cnt_q          <= 5'd0;
            health_q       <= MAX_HEALTH;
            ko_q           <= 1'b0;
            opponent_hit_q <= 1'b0;
            hitstun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            hit_cand_q     <= hit_cand_d;
            cnt_q          <= cnt_d;
            health_q       <= health_d;
            ko_q           <= ko_d;
            opponent_hit_q <= opponent_hit_d;
            hitstun_q      <= hitstun_d;
        end
    end

    assign opponent_hit = opponent_hit_q;
    assign hitstun      = hitstun_q;
    assign opp_health   = health_q;
    assign ko           = ko_q;

endmodule

// File: tb/tb_fireball_hit_detect.sv
// Directed bench for fireball_hit_detect: sweeps, blocking, misses, one-hit-per-launch,
// KO saturation, mid-stun reset and screen-edge clamping.
module tb_fireball_hit_detect;

    localparam logic [1:0] FbDis = 2'b00;
    localparam logic [1:0] FbEn  = 2'b01;
    localparam logic [1:0] FbExp = 2'b10;

    logic       clk = 1'b0;
    logic       start;
    logic [1:0] fb_state;
    logic [9:0] fb_x, fb_y, opp_x, opp_y;
    logic       opp_blocking;
    logic       opponent_hit, hitstun, ko;
    logic [6:0] opp_health;

    int tests_run   = 0;
    int tests_fail  = 0;
    int cyc         = 0;
    int pulses      = 0;
    int pulse_cyc   = -1;
    int stun_cycles = 0;
    int stun_first  = -1;

    fireball_hit_detect dut (
        .clk          (clk),
        .start        (start),
        .fb_state     (fb_state),
        .fb_x         (fb_x),
        .fb_y         (fb_y),
        .opp_x        (opp_x),
        .opp_y        (opp_y),
        .opp_blocking (opp_blocking),
        .opponent_hit (opponent_hit),
        .hitstun      (hitstun),
        .opp_health   (opp_health),
        .ko           (ko)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            tests_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock; outputs sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (opponent_hit) begin
            pulses++;
            pulse_cyc = cyc;
        end
        if (hitstun) begin
            if (stun_first < 0) stun_first = cyc;
            stun_cycles++;
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_counts();
        cyc = 0; pulses = 0; pulse_cyc = -1; stun_cycles = 0; stun_first = -1;
    endtask

    task automatic do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        clear_counts();
    endtask

    task automatic sweep(input logic [9:0] y);
        fb_state = FbEn;
        fb_y     = y;
        for (int i = 0; i < 60; i++) begin
            fb_x = 10'(150 + 2 * i);
            step();
        end
        fb_state = FbDis;
    endtask

    initial begin
        start = 1'b0; fb_state = FbDis; fb_x = 10'd0; fb_y = 10'd0;
        opp_x = 10'd200; opp_y = 10'd300; opp_blocking = 1'b0;

        // Reset values
        do_reset();
        check_eq("rst_health", int'(opp_health), 100);
        check_eq("rst_ko", int'(ko), 0);
        check_eq("rst_hit", int'(opponent_hit), 0);
        check_eq("rst_stun", int'(hitstun), 0);

        // Unblocked hit: contact first at fb_x=184 (iteration 17), pulse observed at cyc 19
        sweep(10'd280);
        check_eq("hit_pulses", pulses, 1);
        check_eq("hit_pulse_cyc", pulse_cyc, 19);
        check_eq("hit_health", int'(opp_health), 90);
        check_eq("hit_stun_len", stun_cycles, 32);
        check_eq("hit_stun_first", stun_first, 20);

        // Blocked hit
        do_reset();
        opp_blocking = 1'b1;
        sweep(10'd280);
        opp_blocking = 1'b0;
        check_eq("blk_pulses", pulses, 1);
        check_eq("blk_health", int'(opp_health), 98);

        // One row above the hitbox top (253)
        do_reset();
        sweep(10'd252);
        check_eq("above_pulses", pulses, 0);
        check_eq("above_health", int'(opp_health), 100);

        // Exploding fireball parked in the box
        do_reset();
        fb_state = FbExp; fb_x = 10'd200; fb_y = 10'd280;
        steps(20);
        check_eq("expl_pulses", pulses, 0);
        fb_state = FbDis;

        // One hit per launch, then relaunch
        do_reset();
        fb_state = FbEn; fb_x = 10'd200; fb_y = 10'd280;
        steps(100);
        check_eq("launch1_pulses", pulses, 1);
        fb_x = 10'd400;
        steps(5);
        fb_state = FbDis;
        steps(3);
        check_eq("gap_pulses", pulses, 1);
        fb_state = FbEn; fb_x = 10'd200;
        steps(50);
        check_eq("launch2_pulses", pulses, 2);
        check_eq("launch2_health", int'(opp_health), 80);
        fb_state = FbDis;

        // Eleven launches: KO on the tenth, nothing on the eleventh
        do_reset();
        fb_x = 10'd200; fb_y = 10'd280;
        for (int k = 1; k <= 11; k++) begin
            clear_counts();
            fb_state = FbEn;
            steps(40);
            fb_state = FbDis;
            steps(3);
            if (k == 9)  check_eq("ko9_health", int'(opp_health), 10);
            if (k == 10) begin
                check_eq("ko10_pulses", pulses, 1);
                check_eq("ko10_health", int'(opp_health), 0);
                check_eq("ko10_ko", int'(ko), 1);
            end
            if (k == 11) begin
                check_eq("ko11_pulses", pulses, 0);
                check_eq("ko11_health", int'(opp_health), 0);
                check_eq("ko11_stun", stun_cycles, 0);
            end
        end

        // Reset in the third STUN cycle, then confirm the FSM is re-armed
        do_reset();
        fb_state = FbEn; fb_x = 10'd200; fb_y = 10'd280;
        for (int i = 0; i < 10 && !hitstun; i++) step();
        check_eq("mid_stun_seen", int'(hitstun), 1);
        steps(2);
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq("mid_rst_health", int'(opp_health), 100);
        check_eq("mid_rst_stun", int'(hitstun), 0);
        check_eq("mid_rst_hit", int'(opponent_hit), 0);
        steps(2);
        check_eq("rearm_hit", int'(opponent_hit), 1);
        check_eq("rearm_health", int'(opp_health), 90);
        fb_state = FbDis;

        // Left-edge clamp: opp_x=5, fb_x=0
        do_reset();
        opp_x = 10'd5; fb_x = 10'd0; fb_y = 10'd280; fb_state = FbEn;
        steps(5);
        check_eq("clamp_lo_pulses", pulses, 1);

        // Right-edge clamp: opp_x=630, fb_x=639
        do_reset();
        opp_x = 10'd630; fb_x = 10'd639;
        steps(5);
        check_eq("clamp_hi_pulses", pulses, 1);
        fb_state = FbDis;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
        $finish;
    end

endmodule
